mont_share_arbiter: RTL

Two-requester round-robin arbiter and sequencer for one shared 256-bit Montgomery multiplier engine in the RSA256 decryption datapath. The block accepts operand pairs from two clients, for example the squaring path (t·t) and the multiply path (m·t). It serializes their jobs onto the single engine, holds the engine operands stable for the whole operation, and captures the engine's single-cycle result. It then returns the result to the client that owns the job. A watchdog aborts a job when the engine stops responding.

---
 rtl/mont_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mont_share_arbiter.sv
// Round-robin arbiter and sequencer that shares one Montgomery multiplier
// engine between two clients, with a watchdog abort on a silent engine.
module mont_share_arbiter #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy,
  output logic             o_err,
  output logic             o_mont_start,
  output logic [WIDTH-1:0] o_mont_a,
  output logic [WIDTH-1:0] o_mont_b,
  input  logic             i_mont_done,
  input  logic [WIDTH-1:0] i_mont_m,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          owner;
  logic [CW-1:0] wd_cnt;
  logic [CW-1:0] wd_cnt_inc;
  logic          pick1;

  // Handshake: i_reqK is level-sensitive and sampled only in IDLE; the
  // operands are captured on that same edge and o_gntK pulses for one cycle
  // to say so. A request still high after the grant asks for another job.
  always_comb begin
    pick1 = i_req1;
    if (i_req0 && i_req1) begin
      pick1 = ~owner;
    end
  end

  assign wd_cnt_inc  = wd_cnt + CW'(1);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      owner        <= 1'b1;
      wd_cnt       <= '0;
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_done0      <= 1'b0;
      o_done1      <= 1'b0;
      o_result     <= '0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
      o_mont_start <= 1'b0;
      o_mont_a     <= '0;
      o_mont_b     <= '0;
    end else begin
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_done0      <= 1'b0;
      o_done1      <= 1'b0;
      o_mont_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req0 || i_req1) begin
            owner        <= pick1;
            o_mont_a     <= pick1 ? i_a1 : i_a0;
            o_mont_b     <= pick1 ? i_b1 : i_b0;
            wd_cnt       <= '0;
            o_gnt0       <= ~pick1;
            o_gnt1       <= pick1;
            o_mont_start <= 1'b1;
            o_busy       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // A genuine finish wins over a watchdog expiry in the same cycle.
          if (i_mont_done) begin
            o_result <= i_mont_m;
            o_done0  <= ~owner;
            o_done1  <= owner;
            state    <= DONE;
          end else if (wd_cnt_inc == TIMEOUT_CNT) begin
            o_result <= '0;
            o_err    <= 1'b1;
            o_done0  <= ~owner;
            o_done1  <= owner;
            state    <= DONE;
          end else begin
            wd_cnt <= wd_cnt_inc;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
